// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencing controller: owns HI/LO, runs a fixed-latency busy counter, raises D-stage stall.
// Optional madd/maddu accumulate support is enabled by defining MDU_MADD_EN.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op_E,
  input  logic [31:0] rs_E,
  input  logic [31:0] rt_E,
  input  logic        md_D,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // state | meaning
  // IDLE  | no operation in flight; accepts starts and mthi/mtlo
  // BUSY  | counter running; shadow result commits to HI/LO when counter reaches 0
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [63:0]       shadow_q, shadow_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;

  logic              is_mul, is_div;
  logic [63:0]       prod_s, prod_u, mul_res, div_res;
  logic [31:0]       a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;

  always_comb begin
    is_mul = (md_op_E == 4'd1) || (md_op_E == 4'd2);
`ifdef MDU_MADD_EN
    is_mul = is_mul || (md_op_E == 4'd7) || (md_op_E == 4'd8);
`endif
    is_div = (md_op_E == 4'd3) || (md_op_E == 4'd4);
  end

  assign prod_s = {{32{rs_E[31]}}, rs_E} * {{32{rt_E[31]}}, rt_E};
  assign prod_u = {32'h0, rs_E} * {32'h0, rt_E};

  always_comb begin
    mul_res = prod_s;
    case (md_op_E)
      4'd2:    mul_res = prod_u;
`ifdef MDU_MADD_EN
      4'd7:    mul_res = {hi_q, lo_q} + prod_s;
      4'd8:    mul_res = {hi_q, lo_q} + prod_u;
`endif
      default: mul_res = prod_s;
    endcase
  end

  // Signed divide via magnitudes so -2^31 / -1 has a defined (wrapped) result.
  always_comb begin
    a_mag = rs_E[31] ? -rs_E : rs_E;
    b_mag = rt_E[31] ? -rt_E : rt_E;
    q_mag = a_mag / b_mag;
    r_mag = a_mag % b_mag;
    q_s   = (rs_E[31] ^ rt_E[31]) ? -q_mag : q_mag;
    r_s   = rs_E[31] ? -r_mag : r_mag;
    q_u   = rs_E / rt_E;
    r_u   = rs_E % rt_E;
    if (rt_E == 32'h0)
      div_res = {rs_E, 32'hFFFF_FFFF};
    else if (md_op_E == 4'd3)
      div_res = {r_s, q_s};
    else
      div_res = {r_u, q_u};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (is_mul) begin
          shadow_d = mul_res;
          cnt_d    = MULT_LOAD;
          state_d  = BUSY;
        end else if (is_div) begin
          shadow_d = div_res;
          cnt_d    = DIV_LOAD;
          state_d  = BUSY;
        end else if (md_op_E == 4'd5) begin
          hi_d = rs_E;
        end else if (md_op_E == 4'd6) begin
          lo_d = rs_E;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          {hi_d, lo_d} = shadow_q;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy     = (state_q == BUSY);
  assign stall_md = md_D && (busy || is_mul || is_div);
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
